// File: rtl/one_four_demux_reg.sv
`default_nettype none
// ============================================================================
//  Module      : one_four_demux_reg
//  Description : Registered 1-to-4 demultiplexer with valid/ready handshake.
//                A single producer stream is steered, one transfer at a time,
//                into one of four consumer lanes chosen by in_sel. Every lane
//                owns a one-entry output buffer, so a stalled lane never
//                blocks traffic headed for the other lanes. Each lane also
//                keeps an 8-bit wrapping count of accepted transfers.
//
//  Ports
//    clk        : rising-edge clock
//    rst        : synchronous, active-high reset
//    in_data    : producer data (WIDTH bits)
//    in_sel     : destination lane 0..3
//    in_valid   : producer offers a transfer
//    in_ready   : block accepts the offered transfer (combinational)
//    out_data   : lane i data on [i*WIDTH +: WIDTH] (registered)
//    out_valid  : lane i buffer full (registered)
//    out_ready  : consumer i takes lane i this cycle
//    lane_cnt   : lane i accepted-transfer count on [i*8 +: 8] (registered)
//    busy       : any lane holding data
//
//  Revision    : 1.0 - initial release
// ============================================================================
module one_four_demux_reg #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [31:0]          lane_cnt,
    output logic                 busy
);

    localparam int c_LANES = 4;

    // Per-lane state
    logic [WIDTH-1:0] r_buf  [c_LANES];
    logic [c_LANES-1:0] r_full;
    logic [7:0]       r_cnt  [c_LANES];

    // Handshake decode
    logic               w_sel_full;
    logic               w_sel_out_ready;
    logic               w_accept;
    logic [c_LANES-1:0] w_load;
    logic [c_LANES-1:0] w_drain;

    // The selected lane can take new data when it is empty, or when it is
    // being emptied in this same cycle (drain and reload back to back).
    // Only the selected lane's out_ready participates, so a stalled lane
    // elsewhere never affects in_ready. Forced low during reset so nothing
    // the producer offers in the reset cycle counts as accepted.
    assign w_sel_full      = r_full[in_sel];
    assign w_sel_out_ready = out_ready[in_sel];
    assign in_ready        = !rst && (!w_sel_full || w_sel_out_ready);
    assign w_accept        = in_valid && in_ready;

    generate
        for (genvar i = 0; i < c_LANES; i++) begin : g_lane
            localparam logic [1:0] c_LANE_ID = 2'(i);

            assign w_load[i]  = w_accept && (in_sel == c_LANE_ID);
            // out_ready on an empty lane has no effect.
            assign w_drain[i] = r_full[i] && out_ready[i];

            // The buffer is written only on a load, and a load into a full
            // lane is only possible while that lane drains, so the presented
            // data stays stable until the consumer takes it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_buf[i]  <= '0;
                    r_full[i] <= 1'b0;
                    r_cnt[i]  <= 8'd0;
                end else begin
                    if (w_load[i]) begin
                        r_buf[i]  <= in_data;
                        r_full[i] <= 1'b1;
                        r_cnt[i]  <= r_cnt[i] + 8'd1;   // wraps 255 -> 0
                    end else if (w_drain[i]) begin
                        r_full[i] <= 1'b0;
                    end
                end
            end

            assign out_data[i*WIDTH +: WIDTH] = r_buf[i];
            assign lane_cnt[i*8 +: 8]         = r_cnt[i];
        end
    endgenerate

    assign out_valid = r_full;
    assign busy      = |r_full;

endmodule
`default_nettype wire

// File: tb/tb_one_four_demux_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_one_four_demux_reg
//  Description : Self-checking bench for one_four_demux_reg. A table of
//                per-cycle vectors covers reset and basic steering; directed
//                sequences cover backpressure, streaming with counter wrap,
//                cross-lane concurrency and reset while lanes hold data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_one_four_demux_reg;

    localparam int WIDTH = 32;

    logic               clk;
    logic               rst;
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [31:0]        lane_cnt;
    logic               busy;

    int n_checks;
    int n_errors;

    one_four_demux_reg #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lane_cnt  (lane_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         valid;
        logic [1:0]   sel;
        logic [31:0]  data;
        logic [3:0]   ordy;
        logic         exp_ready;   // in_ready before the edge
        logic [3:0]   exp_ov;      // out_valid after the edge
        logic [127:0] exp_od;      // out_data after the edge
        logic [31:0]  exp_cnt;     // lane_cnt after the edge
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic v, input logic [1:0] s,
                         input logic [31:0] d, input logic [3:0] o);
        rst       = r;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = o;
    endtask

    initial begin
        logic [7:0]  e_cnt [4];
        logic [31:0] e_cnt_w;

        n_checks = 0;
        n_errors = 0;

        //            rst valid sel  data          ordy  rdy  ov      out_data {l3,l2,l1,l0}                                            cnt
        vecs[0]  = '{1'b1, 1'b1, 2'd0, 32'hDEADBEEF, 4'hF, 1'b0, 4'b0000, 128'h0,                                                    32'h0};
        vecs[1]  = '{1'b1, 1'b1, 2'd2, 32'hDEADBEEF, 4'hF, 1'b0, 4'b0000, 128'h0,                                                    32'h0};
        vecs[2]  = '{1'b0, 1'b1, 2'd0, 32'hA0A00000, 4'h0, 1'b1, 4'b0001, {32'h0, 32'h0, 32'h0, 32'hA0A00000},                       32'h00000001};
        vecs[3]  = '{1'b0, 1'b1, 2'd1, 32'h000000B1, 4'h0, 1'b1, 4'b0011, {32'h0, 32'h0, 32'hB1, 32'hA0A00000},                      32'h00000101};
        vecs[4]  = '{1'b0, 1'b1, 2'd2, 32'h000000C2, 4'h0, 1'b1, 4'b0111, {32'h0, 32'hC2, 32'hB1, 32'hA0A00000},                     32'h00010101};
        vecs[5]  = '{1'b0, 1'b1, 2'd3, 32'h000000D3, 4'h0, 1'b1, 4'b1111, {32'hD3, 32'hC2, 32'hB1, 32'hA0A00000},                    32'h01010101};
        vecs[6]  = '{1'b0, 1'b0, 2'd0, 32'h11111111, 4'h0, 1'b0, 4'b1111, {32'hD3, 32'hC2, 32'hB1, 32'hA0A00000},                    32'h01010101};
        vecs[7]  = '{1'b0, 1'b0, 2'd1, 32'h11111111, 4'h0, 1'b0, 4'b1111, {32'hD3, 32'hC2, 32'hB1, 32'hA0A00000},                    32'h01010101};
        vecs[8]  = '{1'b0, 1'b0, 2'd2, 32'h11111111, 4'h0, 1'b0, 4'b1111, {32'hD3, 32'hC2, 32'hB1, 32'hA0A00000},                    32'h01010101};
        vecs[9]  = '{1'b0, 1'b0, 2'd3, 32'h11111111, 4'h0, 1'b0, 4'b1111, {32'hD3, 32'hC2, 32'hB1, 32'hA0A00000},                    32'h01010101};
        // Same-lane drain and reload; other full lanes keep their data.
        vecs[10] = '{1'b0, 1'b1, 2'd2, 32'h000000EE, 4'h4, 1'b1, 4'b1111, {32'hD3, 32'hEE, 32'hB1, 32'hA0A00000},                    32'h01020101};
        // Drain everything; buffers keep their last contents.
        vecs[11] = '{1'b0, 1'b0, 2'd0, 32'h0,        4'hF, 1'b1, 4'b0000, {32'hD3, 32'hEE, 32'hB1, 32'hA0A00000},                    32'h01020101};
        vecs[12] = '{1'b0, 1'b0, 2'd3, 32'h0,        4'h0, 1'b1, 4'b0000, {32'hD3, 32'hEE, 32'hB1, 32'hA0A00000},                    32'h01020101};

        drive(1'b1, 1'b0, 2'd0, 32'h0, 4'h0);
        tick();

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].sel, vecs[i].data, vecs[i].ordy);
            #1;
            chk($sformatf("v%0d in_ready", i), 128'(in_ready), 128'(vecs[i].exp_ready));
            tick();
            chk($sformatf("v%0d out_valid", i), 128'(out_valid), 128'(vecs[i].exp_ov));
            chk($sformatf("v%0d out_data", i),  out_data,        vecs[i].exp_od);
            chk($sformatf("v%0d lane_cnt", i),  128'(lane_cnt),  128'(vecs[i].exp_cnt));
            chk($sformatf("v%0d busy", i),      128'(busy),      128'(|vecs[i].exp_ov));
        end

        // ---------------- backpressure / stability on lane 2 ----------------
        drive(1'b0, 1'b1, 2'd2, 32'h55, 4'h0);
        #1 chk("bp load ready", 128'(in_ready), 128'(1'b1));
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, 2'd2, 32'h66, 4'h0);
            #1 chk("bp stall ready", 128'(in_ready), 128'(1'b0));
            tick();
            chk("bp stable data", 128'(out_data[2*WIDTH +: WIDTH]), 128'(32'h55));
            chk("bp stall cnt",   128'(lane_cnt), 128'(32'h01030101));
        end
        // Other lanes stay available while lane 2 is stalled.
        drive(1'b0, 1'b0, 2'd0, 32'h66, 4'h0);
        #1 chk("bp lane0 free", 128'(in_ready), 128'(1'b1));
        drive(1'b0, 1'b1, 2'd2, 32'h66, 4'b0100);
        #1 chk("bp release ready", 128'(in_ready), 128'(1'b1));
        tick();
        drive(1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
        #1;
        chk("bp new valid", 128'(out_valid), 128'(4'b0100));
        chk("bp new data",  128'(out_data[2*WIDTH +: WIDTH]), 128'(32'h66));
        chk("bp new cnt",   128'(lane_cnt), 128'(32'h01040101));

        // ---------------- streaming 300 transfers into lane 1 ----------------
        drive(1'b1, 1'b0, 2'd0, 32'h0, 4'h0);
        tick();
        chk("reset2 cnt", 128'(lane_cnt), 128'(32'h0));
        e_cnt[0] = 8'd0; e_cnt[1] = 8'd0; e_cnt[2] = 8'd0; e_cnt[3] = 8'd0;
        for (int k = 0; k < 300; k++) begin
            drive(1'b0, 1'b1, 2'd1, 32'h1000 + 32'(k), 4'b0010);
            #1 chk($sformatf("stream%0d ready", k), 128'(in_ready), 128'(1'b1));
            tick();
            e_cnt[1] = e_cnt[1] + 8'd1;
            chk($sformatf("stream%0d valid", k), 128'(out_valid), 128'(4'b0010));
            chk($sformatf("stream%0d data", k),
                128'(out_data[1*WIDTH +: WIDTH]), 128'(32'h1000 + 32'(k)));
        end
        e_cnt_w = {e_cnt[3], e_cnt[2], e_cnt[1], e_cnt[0]};
        chk("stream cnt model", 128'(lane_cnt), 128'(e_cnt_w));
        chk("stream cnt 44",    128'(lane_cnt), 128'(32'h00002C00));
        drive(1'b0, 1'b0, 2'd0, 32'h0, 4'b0010);
        tick();
        chk("stream drained", 128'(out_valid), 128'(4'b0000));

        // ---------------- concurrency and mid-operation reset ----------------
        drive(1'b0, 1'b1, 2'd3, 32'h33, 4'h0);
        tick();
        chk("conc lane3 full", 128'(out_valid), 128'(4'b1000));
        drive(1'b0, 1'b1, 2'd0, 32'h44, 4'b1000);
        #1 chk("conc ready", 128'(in_ready), 128'(1'b1));
        tick();
        chk("conc valid", 128'(out_valid), 128'(4'b0001));
        chk("conc data0", 128'(out_data[0 +: WIDTH]), 128'(32'h44));
        drive(1'b0, 1'b1, 2'd3, 32'h77, 4'h0);
        tick();
        chk("conc both full", 128'(out_valid), 128'(4'b1001));
        chk("conc cnt", 128'(lane_cnt), 128'(32'h02002C01));
        drive(1'b1, 1'b1, 2'd1, 32'h99, 4'hF);
        #1 chk("mid rst ready", 128'(in_ready), 128'(1'b0));
        tick();
        drive(1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
        #1;
        chk("mid rst valid", 128'(out_valid), 128'(4'b0000));
        chk("mid rst cnt",   128'(lane_cnt),  128'(32'h0));
        chk("mid rst data",  out_data,        128'h0);
        chk("mid rst busy",  128'(busy),      128'(1'b0));
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1 chk($sformatf("post rst ready sel%0d", s), 128'(in_ready), 128'(1'b1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/one_four_demux_reg.md
# one_four_demux_reg

Registered 1-to-4 demultiplexer with valid/ready handshaking. It steers a single WIDTH-bit producer stream into one of four consumer lanes, selected per transfer by a 2-bit lane select. It is the distribution-side counterpart of the 4:1 select path used in the pipelined core. Each lane has a one-entry output buffer, so a stalled lane never blocks transfers to the other lanes. Per-lane transfer counters are provided for debug and performance counting.

## Interface
Parameters:
- WIDTH, 32, data width of the input and of each lane.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  producer data.
- in_sel  input  2  destination lane: 2'b00 = lane 0, 2'b01 = lane 1, 2'b10 = lane 2, 2'b11 = lane 3.
- in_valid  input  1  producer has a transfer.
- in_ready  output  1  block accepts the transfer this cycle. Combinational.
- out_data  output  4*WIDTH  lane i data is on bits [i*WIDTH +: WIDTH]. Registered.
- out_valid  output  4  lane i buffer holds data. Registered.
- out_ready  input  4  consumer i accepts lane i this cycle.
- lane_cnt  output  32  lane i accepted-transfer count on bits [i*8 +: 8]. Registered.
- busy  output  1  OR of out_valid. Combinational from registers.

## Operation
- Each lane i has a buffer buf[i] (WIDTH bits) and a full flag full[i]. out_valid[i] = full[i]; out_data lane i = buf[i].
- in_ready = !rst && (!full[in_sel] || out_ready[in_sel]).
  - It depends on in_sel and on out_ready of the selected lane only.
  - in_ready is valid whether or not in_valid is asserted.
- Accept: occurs when in_valid && in_ready. On an accept, buf[in_sel] <= in_data, full[in_sel] <= 1, and lane_cnt[in_sel] increments.
- Drain: occurs on lane i when full[i] && out_ready[i]. full[i] <= 0 unless the same lane is loaded in the same cycle.
- Simultaneous drain and load on the same lane: full stays 1 and buf takes the new data. This gives full throughput of 1 transfer/cycle per lane.
- Drains on non-selected lanes proceed independently and concurrently with an accept to another lane.
- buf[i] must not change while full[i] = 1 unless lane i drains in that same cycle (AXI-style stability).
- out_ready[i] while full[i] = 0 is ignored.
- lane_cnt counters are 8-bit and wrap 255 -> 0. They count accepts, not drains.
- in_sel and in_data are don't-care when in_valid = 0. No state changes in that case except drains.

## Timing
- Latency: data accepted at edge N appears on out_data and out_valid after edge N, i.e. visible in cycle N+1.
- Minimum in-to-out latency is 1 cycle. There is no combinational data path from in to out.
- Reset, with rst sampled high at a clock edge:
  - full = 4'b0000, buf = 0, lane_cnt = 0.
  - Result: out_valid = 0, out_data = 0, lane_cnt = 0, busy = 0.
  - in_ready = 0 while rst is high.
- Reset mid-operation: all buffered data is discarded without being presented, even if out_ready is high in the reset cycle.
  - out_valid is 0 from the cycle after the reset edge.
  - Any accept requested in the reset cycle is dropped.
- First cycle after rst deasserts: all lanes are empty, so in_ready = 1 for any in_sel.
- Full lane with out_ready low: in_ready = 0 for that in_sel.
  - The producer must hold in_valid, in_data and in_sel until accepted.
  - The producer may change in_sel to a free lane. The block imposes no ordering across lanes.
- Backpressure propagates combinationally through in_ready in the same cycle. No extra bubble is inserted.

## Test plan
- Reset: drive rst = 1 for 2 cycles with in_valid = 1 and out_ready = 4'hF.
  - Expect out_valid = 0, out_data = 0, lane_cnt = 0, busy = 0 and in_ready = 0 throughout reset.
  - Expect in_ready = 1 on the first cycle after rst falls.
- Basic steering: send 0xA0A0_0000 to lane 0, 0xB1 to lane 1, 0xC2 to lane 2 and 0xD3 to lane 3 on consecutive cycles, with out_ready = 0.
  - Expect each lane valid 1 cycle after its accept with the exact data.
  - Expect lane_cnt = 32'h01010101 and busy = 1.
  - Expect in_ready = 0 for any in_sel afterwards.
- Backpressure / stability: fill lane 2 with 0x55 and hold out_ready[2] = 0 for 5 cycles while offering 0x66 to lane 2.
  - Expect in_ready = 0, out_data lane 2 stable at 0x55, and no count change.
  - Raise out_ready[2]: the same cycle gives in_ready = 1. The next cycle shows 0x66 valid, with lane_cnt[2] incremented by 1.
- Streaming: 300 back-to-back transfers to lane 1 with out_ready[1] = 1.
  - Expect 1 transfer/cycle, out_valid[1] continuously 1 after the first, and data in order.
  - Expect lane_cnt[1] = 300 mod 256 = 44.
- Concurrency and mid-reset: lane 3 full and draining while new data goes to lane 0 in the same cycle. Both complete.
  - Then, with lanes 0 and 3 full, assert rst for 1 cycle with out_ready = 4'hF.
  - Expect out_valid = 0 the next cycle, lane_cnt = 0, and no transfer of the buffered data counted.
